// File: rtl/kbd_io_pkg.sv
// Shared types and constants for the PS/2 keyboard i/o device.
// Covers receiver states, register offsets, status bit positions and the frame check.
package kbd_io_pkg;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int unsigned ST_READY = 0;
    localparam int unsigned ST_OVF   = 1;
    localparam int unsigned ST_FERR  = 2;

    // A frame is good when the stop bit is 1 and data+parity carry odd parity.
    function automatic logic frame_ok(logic [7:0] data, logic par, logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Scan-code FIFO with count-based full/empty and a combinational head byte.
// A pop on an empty FIFO is ignored; a push into a full FIFO succeeds only alongside a real pop.
module kbd_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       empty,
    output logic       drop
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, push_ok, pop_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(FIFO_DEPTH));
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        drop    = push & full & ~pop_ok;
        head    = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd_io.sv
// PS/2 keyboard receiver mapped into CPU i/o space: conditions the PS/2 lines,
// deframes scan codes into a FIFO, and exposes DATA/STATUS registers to lw/sw.
module ps2_kbd_io
    import kbd_io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 10000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        io_rdn,
    input  logic        io_wrn,
    input  logic        io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        kbd_ready,
    output logic        kbd_overflow
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_clk_q, filt_flip, sample_evt, sample;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          tmo_hit, frame_done, good_byte, bad_frame;

    logic          ovf_q, ferr_q, fifo_empty, fifo_drop, pop_req, wr_status;
    logic [7:0]    fifo_head;
    logic          unused_wdata;

    assign unused_wdata = ^{io_wdata[31:3], io_wdata[0]};

    always_comb begin
        filt_flip  = (clk_sync_q[1] != filt_clk_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
        sample_evt = filt_clk_q & filt_flip;
        sample     = dat_sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_cnt_q <= '0;
            filt_clk_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            if (clk_sync_q[1] == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_flip) begin
                filt_clk_q <= ~filt_clk_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        tmo_hit = (state_q != StIdle) && !sample_evt && (tmo_q == TW'(TIMEOUT - 1));
        state_d = state_q;
        if (tmo_hit) begin
            state_d = StIdle;
        end else if (sample_evt) begin
            unique case (state_q)
                StIdle:   if (!sample) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        frame_done = sample_evt && (state_q == StStop);
        good_byte  = frame_done && frame_ok(shift_q, par_q, sample);
        bad_frame  = frame_done && !good_byte;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            if (state_q == StIdle || sample_evt) tmo_q <= '0;
            else                                 tmo_q <= tmo_q + TW'(1);
            if (sample_evt) begin
                case (state_q)
                    StIdle:   bit_cnt_q <= '0;
                    StData: begin
                        shift_q   <= {sample, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    StParity: par_q <= sample;
                    default:  ;
                endcase
            end
        end
    end

    assign pop_req   = !io_rdn && (io_addr == REG_DATA);
    assign wr_status = !io_wrn && (io_addr == REG_STATUS);

    kbd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (good_byte),
        .pop   (pop_req),
        .wdata (shift_q),
        .head  (fifo_head),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    // Set has priority over a write-1-to-clear in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (fifo_drop)                         ovf_q <= 1'b1;
            else if (wr_status && io_wdata[ST_OVF]) ovf_q <= 1'b0;
            if (bad_frame)                          ferr_q <= 1'b1;
            else if (wr_status && io_wdata[ST_FERR]) ferr_q <= 1'b0;
        end
    end

    always_comb begin
        kbd_ready    = !fifo_empty;
        kbd_overflow = ovf_q;
        io_rdata     = '0;
        if (io_addr == REG_STATUS) begin
            io_rdata[ST_READY] = kbd_ready;
            io_rdata[ST_OVF]   = ovf_q;
            io_rdata[ST_FERR]  = ferr_q;
        end else if (!fifo_empty) begin
            io_rdata[7:0] = fifo_head;
        end
    end

endmodule

// File: doc/ps2_kbd_io.md
Name: ps2_kbd_io

Overview:
- Keyboard input device in the CPU's i/o space (a0000000-bfffffff).
- Directly downstream of the single-cycle CPU's io_rdn/io_wrn strobes; its read data feeds the CPU load-data mux.
- Receives PS/2 frames, checks parity and stop bit, and buffers scan codes in a FIFO.
- The CPU polls status and pops codes with lw, and clears sticky error flags with sw.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, at least 2.
- FILTER_LEN, 8, consecutive equal samples required before the filtered ps2_clk changes.
- TIMEOUT, 10000, clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- io_rdn  in  1  i/o read strobe, active-low, held for one CPU cycle per lw.
- io_wrn  in  1  i/o write strobe, active-low.
- io_addr  in  1  register select (m_addr[2]): 0 = DATA, 1 = STATUS.
- io_wdata  in  32  store data.
- io_rdata  out  32  load data, combinational.
- kbd_ready  out  1  FIFO non-empty.
- kbd_overflow  out  1  sticky: a valid frame was dropped because the FIFO was full.

Behaviour:
- Reset (clr high at a clk edge):
  - FIFO empty, pointers and count 0.
  - FSM to IDLE, bit counter 0, timeout counter 0.
  - overflow and frame_err cleared.
  - Sync flops and filtered clock set to 1.
  - Resulting outputs: kbd_ready=0, kbd_overflow=0, io_rdata=0.
  - A reset mid-frame discards the partial frame.
- Input conditioning:
  - Two-flop synchroniser on each of ps2_clk and ps2_data.
  - Filtered clock changes only after FILTER_LEN consecutive synchronised samples at the new level.
  - A sample event is the clk cycle in which filtered ps2_clk goes 1->0; ps2_data (synchronised) is sampled in that cycle.
- Receive FSM, stepping on sample events:
  - IDLE: data 0 -> DATA with bit_cnt=0; data 1 -> stay in IDLE (false start ignored).
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: if stop bit = 1 and data bits plus parity have odd parity, the byte is good; otherwise set frame_err and discard. Either way -> IDLE.
  - Timeout: in any non-IDLE state, TIMEOUT cycles with no sample event -> IDLE, partial frame discarded, frame_err unchanged.
- Push:
  - A good byte is pushed at the same clk edge that processes the STOP sample; kbd_ready is high from the next cycle.
  - FIFO full at a push with no pop in that cycle: byte dropped, overflow set.
- Read:
  - io_addr=0: io_rdata = {24'h0, head byte} if non-empty, else 0.
  - io_addr=1: io_rdata = {29'h0, frame_err, overflow, ready}.
  - io_rdata is driven regardless of io_rdn.
- Pop:
  - Occurs at the posedge where io_rdn=0, io_addr=0, and the FIFO is non-empty.
  - Pop while empty is ignored.
  - io_rdn held low for N cycles pops up to N entries.
  - Reading STATUS never pops.
- Simultaneous events:
  - Push and pop while full: both occur, count unchanged, no overflow.
  - Push and pop while empty: pop ignored, push occurs.
- Write:
  - io_wrn=0 with io_addr=1 is write-1-to-clear: io_wdata[1] clears overflow, io_wdata[2] clears frame_err.
  - Writes to DATA are ignored.
  - If a flag is set and cleared in the same cycle, set wins.
- FIFO count is width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package kbd_io_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Register offsets: REG_DATA=0, REG_STATUS=1.
  - Status bit positions: ST_READY=0, ST_OVF=1, ST_FERR=2.
- Sub-module kbd_fifo: synchronous FIFO with count-based full/empty, combinational head output, and push/pop priority as above.
- Synchroniser, filter, and FSM stay in ps2_kbd_io.

Test Plan:
1. Reset, then send frame 0x1C with parity 0 -> status read = 0x1 with no pop; DATA read = 0x0000001C; next cycle kbd_ready=0 and status = 0x0.
2. Send 0x1C with parity 1 -> FIFO stays empty; status = 0x4. sw 0x4 to STATUS -> status = 0x0.
3. Send 0x01..0x09 without reading -> status = 0x3; eight DATA reads return 0x01..0x08, then 0. sw 0x2 to STATUS -> overflow clears.
4. Send start bit plus 4 data bits, idle TIMEOUT+10 cycles, then send full frame 0xF0 -> FIFO holds only 0xF0; frame_err=0.
5. Fill the FIFO with 0x10..0x17; pop in the same cycle a frame 0x18 completes -> count stays 8, overflow=0, reads return 0x11..0x18.
6. ps2_clk low glitch of FILTER_LEN-2 cycles -> no state change. Assert clr mid-frame -> FSM IDLE; the next full frame 0x5A is received correctly.
